// File: rtl/pid_steer_ctrl_if.sv
// pid_steer_ctrl_if
//   Bundles the steering controller's sample inputs and wheel-speed outputs.
//   master: producer of error samples / consumer of speeds (e.g. navigation).
//   slave : the steering controller itself.
// Signals:
//   moving   drive enabled
//   err_vld  error sample valid this cycle
//   error    signed heading error (ERR_W)
//   frwrd    unsigned forward speed command (FRWRD_W)
//   i_clr    clear integrator
//   lft_spd  signed left wheel speed (SPD_W)
//   rght_spd signed right wheel speed (SPD_W)
//   spd_vld  one-cycle strobe: speeds updated
//   sat_flag last update clamped either speed
interface pid_steer_ctrl_if #(
  parameter int ERR_W   = 12,
  parameter int FRWRD_W = 10,
  parameter int SPD_W   = 11
);
  logic                      moving;
  logic                      err_vld;
  logic signed [ERR_W-1:0]   error;
  logic        [FRWRD_W-1:0] frwrd;
  logic                      i_clr;
  logic signed [SPD_W-1:0]   lft_spd;
  logic signed [SPD_W-1:0]   rght_spd;
  logic                      spd_vld;
  logic                      sat_flag;

  modport master (
    output moving, err_vld, error, frwrd, i_clr,
    input  lft_spd, rght_spd, spd_vld, sat_flag
  );

  modport slave (
    input  moving, err_vld, error, frwrd, i_clr,
    output lft_spd, rght_spd, spd_vld, sat_flag
  );
endinterface

// File: rtl/pid_steer_ctrl.sv
// pid_steer_ctrl
//   PID steering controller: turns a signed heading error and an unsigned
//   forward command into signed left/right wheel speeds. Outputs are
//   registered and update only on accepted (err_vld & moving) samples.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  pid_steer_ctrl_if.slave (moving, err_vld, error, frwrd, i_clr in;
//        lft_spd, rght_spd, spd_vld, sat_flag out)
module pid_steer_ctrl #(
  parameter int ERR_W     = 12,
  parameter int ESAT_W    = 10,
  parameter int FRWRD_W   = 10,
  parameter int SPD_W     = 11,
  parameter int P_COEFF   = 6,
  parameter int D_COEFF   = 5,
  parameter int I_W       = 15,
  parameter int I_SHIFT   = 4,
  parameter int D_SAT_W   = 7,
  parameter int D_DEPTH   = 2,
  parameter int OUT_SHIFT = 3
) (
  input logic            clk,
  input logic            rst,
  pid_steer_ctrl_if.slave bus
);

  localparam int P_W   = ESAT_W + 4;
  localparam int MIX_W = SPD_W + 2;
  localparam int DIF_W = ESAT_W + 1;

  localparam logic signed [ERR_W-1:0] E_HI = ERR_W'((1 << (ESAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0] E_LO = ERR_W'(-(1 << (ESAT_W - 1)));
  localparam logic signed [DIF_W-1:0] D_HI = DIF_W'((1 << (D_SAT_W - 1)) - 1);
  localparam logic signed [DIF_W-1:0] D_LO = DIF_W'(-(1 << (D_SAT_W - 1)));
  localparam logic signed [MIX_W-1:0] S_HI = MIX_W'((1 << (SPD_W - 1)) - 1);
  localparam logic signed [MIX_W-1:0] S_LO = MIX_W'(-(1 << (SPD_W - 1)));

  logic signed [ESAT_W-1:0]  err_sat;
  logic signed [ESAT_W-1:0]  hist [D_DEPTH];
  logic signed [I_W-1:0]     integ;
  logic signed [I_W-1:0]     i_sum;
  logic                      i_ovf;
  logic signed [DIF_W-1:0]   d_raw;
  logic signed [D_SAT_W-1:0] d_sat;
  logic signed [P_W-1:0]     p_term;
  logic signed [P_W-1:0]     i_term;
  logic signed [P_W-1:0]     d_term;
  logic signed [P_W-1:0]     pid;
  logic signed [P_W-1:0]     mix;
  logic signed [MIX_W-1:0]   fwd_ext;
  logic signed [MIX_W-1:0]   lft_raw;
  logic signed [MIX_W-1:0]   rght_raw;
  logic signed [SPD_W-1:0]   lft_c;
  logic signed [SPD_W-1:0]   rght_c;
  logic                      lft_clip;
  logic                      rght_clip;

  logic signed [SPD_W-1:0]   lft_q;
  logic signed [SPD_W-1:0]   rght_q;
  logic                      vld_q;
  logic                      sat_q;

  always_comb begin
    if (bus.error > E_HI)      err_sat = ESAT_W'(E_HI);
    else if (bus.error < E_LO) err_sat = ESAT_W'(E_LO);
    else                       err_sat = ESAT_W'(bus.error);
  end

  // Integrator add with overflow detect: wrap is only possible when both
  // operands share a sign and the sum's sign differs.
  always_comb begin
    i_sum = integ + I_W'(err_sat);
    i_ovf = (integ[I_W-1] == err_sat[ESAT_W-1]) && (i_sum[I_W-1] != integ[I_W-1]);
  end

  // Derivative against the oldest history entry, clamped before the gain.
  always_comb begin
    d_raw = DIF_W'(err_sat) - DIF_W'(hist[D_DEPTH-1]);
    if (d_raw > D_HI)      d_sat = D_SAT_W'(D_HI);
    else if (d_raw < D_LO) d_sat = D_SAT_W'(D_LO);
    else                   d_sat = D_SAT_W'(d_raw);
  end

  // I term uses the register value from before this edge's update.
  always_comb begin
    p_term = P_W'(err_sat) * P_W'(P_COEFF);
    i_term = P_W'(integ >>> I_SHIFT);
    d_term = P_W'(d_sat) * P_W'(D_COEFF);
    pid    = p_term + i_term + d_term;
    mix    = pid >>> OUT_SHIFT;
  end

  always_comb begin
    fwd_ext  = MIX_W'({1'b0, bus.frwrd});
    lft_raw  = fwd_ext + MIX_W'(mix);
    rght_raw = fwd_ext - MIX_W'(mix);

    lft_clip = 1'b1;
    if (lft_raw > S_HI)      lft_c = SPD_W'(S_HI);
    else if (lft_raw < S_LO) lft_c = SPD_W'(S_LO);
    else begin
      lft_c    = SPD_W'(lft_raw);
      lft_clip = 1'b0;
    end

    rght_clip = 1'b1;
    if (rght_raw > S_HI)      rght_c = SPD_W'(S_HI);
    else if (rght_raw < S_LO) rght_c = SPD_W'(S_LO);
    else begin
      rght_c    = SPD_W'(rght_raw);
      rght_clip = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ  <= '0;
      for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
      lft_q  <= '0;
      rght_q <= '0;
      vld_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      if (bus.i_clr || !bus.moving) integ <= '0;
      else if (bus.err_vld && !i_ovf) integ <= i_sum;

      // History keeps tracking the error even while stopped.
      if (bus.err_vld) begin
        hist[0] <= err_sat;
        for (int k = 1; k < D_DEPTH; k++) hist[k] <= hist[k-1];
      end

      if (!bus.moving) begin
        lft_q  <= '0;
        rght_q <= '0;
        vld_q  <= 1'b0;
        sat_q  <= 1'b0;
      end else if (bus.err_vld) begin
        lft_q  <= lft_c;
        rght_q <= rght_c;
        vld_q  <= 1'b1;
        sat_q  <= lft_clip | rght_clip;
      end else begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.spd_vld  = vld_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_pid_steer_ctrl.sv
// tb_pid_steer_ctrl
//   Directed bench for pid_steer_ctrl with an integer-arithmetic reference
//   model compared every cycle, plus hand-computed literal expectations.
module tb_pid_steer_ctrl;
  localparam int ERR_W = 12, ESAT_W = 10, FRWRD_W = 10, SPD_W = 11;
  localparam int P_COEFF = 6, D_COEFF = 5, I_W = 15, I_SHIFT = 4;
  localparam int D_SAT_W = 7, D_DEPTH = 2, OUT_SHIFT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  pid_steer_ctrl_if #(.ERR_W(ERR_W), .FRWRD_W(FRWRD_W), .SPD_W(SPD_W)) bus ();

  pid_steer_ctrl #(
    .ERR_W(ERR_W), .ESAT_W(ESAT_W), .FRWRD_W(FRWRD_W), .SPD_W(SPD_W),
    .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .I_W(I_W), .I_SHIFT(I_SHIFT),
    .D_SAT_W(D_SAT_W), .D_DEPTH(D_DEPTH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_integ = 0;
  int m_hist[$];
  int exp_l = 0, exp_r = 0, exp_v = 0, exp_s = 0;

  function automatic int clampi(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int floor_div(int v, int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  always @(posedge clk) begin
    int es, p, i, d, pid, m, l, r, lc, rc, s;
    if (rst) begin
      m_integ = 0;
      m_hist = {};
      for (int k = 0; k < D_DEPTH; k++) m_hist.push_back(0);
      exp_l = 0; exp_r = 0; exp_v = 0; exp_s = 0;
    end else begin
      es  = clampi(int'(bus.error), -(1 << (ESAT_W-1)), (1 << (ESAT_W-1)) - 1);
      p   = es * P_COEFF;
      i   = floor_div(m_integ, 1 << I_SHIFT);
      d   = clampi(es - m_hist[0], -(1 << (D_SAT_W-1)), (1 << (D_SAT_W-1)) - 1) * D_COEFF;
      pid = p + i + d;
      m   = floor_div(pid, 1 << OUT_SHIFT);
      l   = int'(bus.frwrd) + m;
      r   = int'(bus.frwrd) - m;
      lc  = clampi(l, -(1 << (SPD_W-1)), (1 << (SPD_W-1)) - 1);
      rc  = clampi(r, -(1 << (SPD_W-1)), (1 << (SPD_W-1)) - 1);
      if (!bus.moving) begin
        exp_l = 0; exp_r = 0; exp_v = 0; exp_s = 0;
      end else if (bus.err_vld) begin
        exp_l = lc; exp_r = rc; exp_v = 1;
        exp_s = ((lc != l) || (rc != r)) ? 1 : 0;
      end else begin
        exp_v = 0;
      end
      if (bus.i_clr || !bus.moving) m_integ = 0;
      else if (bus.err_vld) begin
        s = m_integ + es;
        if (s >= -(1 << (I_W-1)) && s <= (1 << (I_W-1)) - 1) m_integ = s;
      end
      if (bus.err_vld) begin
        m_hist.push_back(es);
        void'(m_hist.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 4;
      if (int'(bus.lft_spd) != exp_l) begin
        errors++;
        $display("FAIL model_lft @%0t: got %0d expected %0d", $time, bus.lft_spd, exp_l);
      end
      if (int'(bus.rght_spd) != exp_r) begin
        errors++;
        $display("FAIL model_rght @%0t: got %0d expected %0d", $time, bus.rght_spd, exp_r);
      end
      if (int'(bus.spd_vld) != exp_v) begin
        errors++;
        $display("FAIL model_vld @%0t: got %0d expected %0d", $time, bus.spd_vld, exp_v);
      end
      if (int'(bus.sat_flag) != exp_s) begin
        errors++;
        $display("FAIL model_sat @%0t: got %0d expected %0d", $time, bus.sat_flag, exp_s);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic outs(input string name, input int l, input int r, input int v, input int s);
    lit({name, "_lft"},  int'(bus.lft_spd),  l);
    lit({name, "_rght"}, int'(bus.rght_spd), r);
    lit({name, "_vld"},  int'(bus.spd_vld),  v);
    lit({name, "_sat"},  int'(bus.sat_flag), s);
  endtask

  // Inputs change just after a negedge; returns at the following negedge,
  // by which time the outputs reflect this cycle's sample.
  task automatic step(input logic vld, input int err, input int fr, input logic mov, input logic clr);
    bus.err_vld = vld;
    bus.error   = ERR_W'(err);
    bus.frwrd   = FRWRD_W'(fr);
    bus.moving  = mov;
    bus.i_clr   = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bus.err_vld = 1'b0; bus.error = '0; bus.frwrd = '0; bus.moving = 1'b0; bus.i_clr = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a live sample present.
    rst = 1'b1;
    step(1'b1, 100, 256, 1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 100, 256, 1'b1, 1'b0);
    outs("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Single positive sample from clean state, then hold with strobe low.
    step(1'b1, 100, 256, 1'b1, 1'b0);
    outs("pos", 370, 142, 1, 0);
    step(1'b0, 100, 256, 1'b1, 1'b0);
    outs("pos_hold", 370, 142, 0, 0);

    do_reset();
    step(1'b1, -100, 0, 1'b1, 1'b0);
    outs("neg", -115, 115, 1, 0);

    do_reset();
    step(1'b1, 2047, 1023, 1'b1, 1'b0);
    outs("sat_pos", 1023, 601, 1, 1);

    do_reset();
    step(1'b1, -2048, 1023, 1'b1, 1'b0);
    outs("sat_neg", 599, 1023, 1, 1);

    // Anti-windup: 40 back-to-back samples at the positive rail.
    do_reset();
    for (int n = 0; n < 32; n++) step(1'b1, 511, 0, 1'b1, 1'b0);
    lit("integ_32", m_integ, 16352);
    for (int n = 0; n < 8; n++) step(1'b1, 511, 0, 1'b1, 1'b0);
    lit("integ_40", m_integ, 16352);
    outs("windup", 511, -511, 1, 0);

    // Clear, then a sample sees I = 0.
    step(1'b0, 511, 0, 1'b1, 1'b1);
    step(1'b1, 511, 0, 1'b1, 1'b0);
    outs("after_clr", 383, -383, 1, 0);
    // Clear coincident with a sample: this sample still uses the pre-clear I.
    step(1'b1, 511, 0, 1'b1, 1'b1);
    outs("clr_with_vld", 387, -387, 1, 0);
    step(1'b1, 511, 0, 1'b1, 1'b0);
    outs("post_clr_vld", 383, -383, 1, 0);

    // Drop moving mid-stream; history keeps advancing with error 0.
    step(1'b1, 0, 300, 1'b0, 1'b0);
    outs("stop", 0, 0, 0, 0);
    step(1'b1, 0, 300, 1'b0, 1'b0);
    step(1'b1, 0, 300, 1'b0, 1'b0);
    step(1'b1, 0, 300, 1'b1, 1'b0);
    outs("restart", 300, 300, 1, 0);

    // Reset mid-operation overrides a live sample.
    step(1'b1, 100, 256, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 100, 256, 1'b1, 1'b1);
    outs("mid_reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Mixed directed stream, model-checked every cycle.
    step(1'b1,   40, 500, 1'b1, 1'b0);
    step(1'b1,  -30, 500, 1'b1, 1'b0);
    step(1'b0,  900, 500, 1'b1, 1'b0);
    step(1'b1,  900, 700, 1'b1, 1'b0);
    step(1'b1, -900, 700, 1'b1, 1'b0);
    step(1'b1, -600,  10, 1'b1, 1'b0);
    step(1'b1,    5,  10, 1'b1, 1'b0);
    step(1'b0,    5,  10, 1'b1, 1'b0);
    for (int n = 0; n < 40; n++) step(1'b1, -512, 200, 1'b1, 1'b0);
    step(1'b1, 0, 200, 1'b1, 1'b0);
    step(1'b0, 0, 200, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pid_steer_ctrl.md
# pid_steer_ctrl

Parametrised PID steering controller for the drive path, successor to the fixed-width PID block. It converts a signed heading error and a forward speed command into signed left/right wheel speeds. Widths, gains and derivative history depth are parameters. New behaviour over the fixed block:
- registered output stage with a valid strobe;
- explicit integrator clear;
- saturation flag;
- outputs update only on valid error samples.

## Interface
Parameters:
- ERR_W, 12, input error width
- ESAT_W, 10, saturated error width
- FRWRD_W, 10, forward command width (unsigned)
- SPD_W, 11, output speed width (signed); must be ≥ FRWRD_W+1
- P_COEFF, 6, proportional gain (positive integer)
- D_COEFF, 5, derivative gain (positive integer)
- I_W, 15, integrator width; I_SHIFT, 4, integrator output right-shift
- D_SAT_W, 7, saturated derivative-difference width
- D_DEPTH, 2, derivative compares against the error D_DEPTH valid samples earlier (≥1)
- OUT_SHIFT, 3, arithmetic right-shift applied to the PID sum before mixing

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- moving  in  1  drive enabled
- err_vld  in  1  error sample valid this cycle
- error  in  ERR_W  signed heading error
- frwrd  in  FRWRD_W  unsigned forward speed
- i_clr  in  1  clear integrator
- lft_spd  out  SPD_W  signed left speed
- rght_spd  out  SPD_W  signed right speed
- spd_vld  out  1  one-cycle strobe: outputs updated
- sat_flag  out  1  last update clamped either output

## Operation
- err_sat = clamp(error, −2^(ESAT_W−1), 2^(ESAT_W−1)−1).
- P = err_sat·P_COEFF, signed, width ESAT_W+4.
- Integrator (I_W-bit signed register):
  - i_clr or !moving: cleared next edge (highest priority after rst).
  - else on err_vld: sum = integ + sext(err_sat). Update only if no signed overflow (operand signs equal, sum sign differs); otherwise hold.
  - I = integ >>> I_SHIFT, using the pre-update register value.
- Derivative history: D_DEPTH-entry shift register of err_sat, advanced on every err_vld (regardless of moving), reset to 0.
  - diff = err_sat − oldest entry, clamped to D_SAT_W signed (−64..63 default).
  - D = diff·D_COEFF.
- PID = P + I + D at ESAT_W+4 bits. Default ranges cannot overflow.
- Mix: m = PID >>> OUT_SHIFT. Compute lft = zext(frwrd) + m and rght = zext(frwrd) − m at SPD_W+2 bits, then clamp each to [−2^(SPD_W−1), 2^(SPD_W−1)−1].
- Output register update rules:
  - err_vld & moving: load clamped lft/rght; sat_flag = either clamped; spd_vld = 1.
  - !moving: lft_spd = rght_spd = 0, sat_flag = 0, spd_vld = 0.
  - otherwise: hold outputs, spd_vld = 0.

## Timing
- Reset values: lft_spd = rght_spd = 0, spd_vld = 0, sat_flag = 0, integrator = 0, history = 0.
- Latency: inputs sampled at edge N with err_vld = 1 → outputs and spd_vld visible after edge N (1 cycle). spd_vld is high exactly one cycle per accepted sample.
- Back-to-back err_vld is supported every cycle. Each sample uses integrator/history state from before that edge.
- moving falling: outputs zero after the same edge; integrator zero after that edge.
- i_clr with err_vld: integrator clears; outputs still update using the pre-clear I.
- rst mid-operation: all state returns to reset values at the next edge; rst overrides all other inputs.

## Test plan
- Reset: hold rst 2 cycles with err_vld = 1, error = 100 → lft_spd = rght_spd = 0, spd_vld = 0, sat_flag = 0.
- Single sample from clean state: moving = 1, frwrd = 256, error = 100, err_vld pulse → next cycle P = 600, I = 0, D = 315, m = 114 → lft_spd = 370, rght_spd = 142, spd_vld = 1 for 1 cycle, sat_flag = 0.
- Negative error, sample from clean state: frwrd = 0, error = −100 → P = −600, D = −320, m = −115 → lft_spd = −115, rght_spd = 115.
- Input and output saturation, sample from clean state: frwrd = 1023, error = 2047 → err_sat = 511, PID = 3381, m = 422 → lft_spd = 1023 (clamped), rght_spd = 601, sat_flag = 1.
- Integrator anti-windup: moving = 1, error = 511, err_vld every cycle for 40 cycles → integrator reaches 16352 after 32 samples and holds (no wrap); I = 1022 thereafter.
- Clear and stop:
  - i_clr pulse → integrator 0 next cycle.
  - Then drop moving mid-stream → outputs 0 and spd_vld 0 after that edge.
  - Reassert moving with error = 0 and err_vld → lft_spd = rght_spd = frwrd.
